// File: rtl/xosera_spi_bus_seq.sv
// xosera_spi_bus_seq: turns SPI CMD/PAYLOAD byte pairs from spi_target into timed Xosera host-bus cycles
//   clk, reset_n_i           pixel clock, asynchronous active-low reset
//   spi_select_i             SPI frame active
//   rx_strobe_i, rx_byte_i   received byte and its 1-cycle valid pulse
//   tx_byte_o                byte shifted out next (read data in PAYLOAD slot, IDLE_BYTE in CMD slot)
//   bus_*_o, bus_data_i      Xosera host bus (cs active low, rd_nwr 1=read)
//   soft_reset_o             1-cycle pulse on an RS command
//   busy_o, overflow_o       activity flag and sticky dropped-pair flag
module xosera_spi_bus_seq #(
    parameter int         FIFO_DEPTH   = 4,
    parameter int         SETUP_CYCLES = 1,
    parameter int         CS_CYCLES    = 2,
    parameter logic [7:0] IDLE_BYTE    = 8'hCB
) (
    input  logic       clk,
    input  logic       reset_n_i,
    input  logic       spi_select_i,
    input  logic       rx_strobe_i,
    input  logic [7:0] rx_byte_i,
    output logic [7:0] tx_byte_o,
    output logic       bus_cs_n_o,
    output logic       bus_rd_nwr_o,
    output logic       bus_bytesel_o,
    output logic [3:0] bus_reg_num_o,
    output logic [7:0] bus_data_o,
    input  logic [7:0] bus_data_i,
    output logic       soft_reset_o,
    output logic       busy_o,
    output logic       overflow_o
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(SETUP_CYCLES > CS_CYCLES ? SETUP_CYCLES : CS_CYCLES) + 1;
    localparam logic [CW-1:0] SETUP_LAST = CW'(SETUP_CYCLES - 1);
    localparam logic [CW-1:0] CS_LAST    = CW'(CS_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_t;

    logic [13:0]   fifo_mem [FIFO_DEPTH];
    logic [13:0]   head;
    logic [AW:0]   wr_ptr, rd_ptr;
    logic [7:0]    cmd_q, rd_data_q;
    logic [CW-1:0] cnt;
    logic          payload_phase, next_phase;
    logic          empty, full, cmd_hit, rs_hit, push_req, push, pop;
    state_t        state;

    assign empty      = wr_ptr == rd_ptr;
    assign full       = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign head       = fifo_mem[rd_ptr[AW-1:0]];
    assign cmd_hit    = rx_strobe_i && !payload_phase;
    assign rs_hit     = cmd_hit && rx_byte_i[5];
    assign push_req   = rx_strobe_i && payload_phase && cmd_q[7] && !cmd_q[5];
    assign pop        = !rs_hit && !empty && (state == IDLE || state == HOLD);
    // a same-cycle pop frees a slot, so a push into a full FIFO is still accepted
    assign push       = push_req && (!full || pop);
    // the strobe is consumed first; a deselect then forces the parser back to CMD
    assign next_phase = spi_select_i && (rx_strobe_i ? !payload_phase : payload_phase);
    assign busy_o     = (state != IDLE) || !empty;

    always_ff @(posedge clk) begin
        if (push)
            fifo_mem[wr_ptr[AW-1:0]] <= {cmd_q[6], cmd_q[4], cmd_q[3:0], rx_byte_i};
    end

    always_ff @(posedge clk or negedge reset_n_i) begin
        if (!reset_n_i) begin
            payload_phase <= 1'b0;
            cmd_q         <= 8'h00;
            tx_byte_o     <= IDLE_BYTE;
            soft_reset_o  <= 1'b0;
            overflow_o    <= 1'b0;
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            rd_data_q     <= 8'h00;
            state         <= IDLE;
            cnt           <= '0;
            bus_cs_n_o    <= 1'b1;
            bus_rd_nwr_o  <= 1'b1;
            bus_bytesel_o <= 1'b0;
            bus_reg_num_o <= 4'h0;
            bus_data_o    <= 8'h00;
        end else begin
            payload_phase <= next_phase;
            soft_reset_o  <= rs_hit;
            if (cmd_hit)
                cmd_q <= rx_byte_i;
            if (next_phase != payload_phase)
                tx_byte_o <= next_phase ? rd_data_q : IDLE_BYTE;
            if (rs_hit) begin
                wr_ptr     <= '0;
                rd_ptr     <= '0;
                overflow_o <= 1'b0;
                state      <= IDLE;
                cnt        <= '0;
                bus_cs_n_o <= 1'b1;
            end else begin
                if (push)
                    wr_ptr <= wr_ptr + 1'b1;
                if (push_req && !push)
                    overflow_o <= 1'b1;
                if (pop) begin
                    rd_ptr        <= rd_ptr + 1'b1;
                    bus_rd_nwr_o  <= !head[13];
                    bus_bytesel_o <= head[12];
                    bus_reg_num_o <= head[11:8];
                    bus_data_o    <= head[7:0];
                    bus_cs_n_o    <= 1'b1;
                    cnt           <= '0;
                    state         <= SETUP;
                end else begin
                    case (state)
                        SETUP: begin
                            cnt <= (cnt == SETUP_LAST) ? '0 : cnt + 1'b1;
                            if (cnt == SETUP_LAST) begin
                                bus_cs_n_o <= 1'b0;
                                state      <= STROBE;
                            end
                        end
                        STROBE: begin
                            cnt <= (cnt == CS_LAST) ? '0 : cnt + 1'b1;
                            if (cnt == CS_LAST) begin
                                bus_cs_n_o <= 1'b1;
                                state      <= HOLD;
                                if (bus_rd_nwr_o)
                                    rd_data_q <= bus_data_i;
                            end
                        end
                        default: state <= IDLE;
                    endcase
                end
            end
        end
    end
endmodule
